// File: rtl/banco_registradores_param_pkg.sv
// ============================================================================
// banco_registradores_param_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the parametrised register file:
//   - clr_state_t : state encoding of the soft-clear engine (ST_IDLE, ST_CLEAR)
//   - DEF_DATA_W  : default register width for the processor datapath
//   - DEF_ADDR_W  : default address width (DEPTH = 2**DEF_ADDR_W)
// No ports; imported by banco_limpeza_fsm and banco_registradores_param.
// ============================================================================
package banco_registradores_param_pkg;

    // Two-state clear engine: idle (normal reads/writes) or sweeping clear.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Processor default geometry: 8 registers of 8 bits.
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/banco_limpeza_fsm.sv
// ============================================================================
// banco_limpeza_fsm
// ----------------------------------------------------------------------------
// Sequenced soft-clear engine for the register file. On a limpa request in
// IDLE it sweeps every index 0..DEPTH-1, one per cycle, then returns to IDLE.
// It also flags writes that arrive while the sweep is running.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   i_limpa        in   soft-clear request (ignored while clearing)
//   i_escrita      in   effective write request from the datapath
//   o_clr_en       out  storage must clear entry o_clr_idx at this edge
//   o_clr_idx      out  index being cleared this cycle
//   o_ocupado      out  clear engine active
//   o_erro_escrita out  one-cycle pulse: a write was dropped last cycle
// ============================================================================
module banco_limpeza_fsm
    import banco_registradores_param_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_limpa,
    input  logic              i_escrita,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_clr_idx,
    output logic              o_ocupado,
    output logic              o_erro_escrita
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clr_state_t        r_state;
    clr_state_t        w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_next_ptr;
    logic              r_erro;

    // Next-state logic. A request is only honoured from IDLE, so a second
    // limpa mid-sweep neither restarts nor stretches the clear. The sweep
    // leaves after the last index, giving exactly DEPTH busy cycles.
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (i_limpa) begin
                    w_next_state = ST_CLEAR;
                    w_next_ptr   = '0;
                end
            end
            ST_CLEAR: begin
                if (r_ptr == LAST_IDX) begin
                    w_next_state = ST_IDLE;
                    w_next_ptr   = '0;
                end else begin
                    w_next_ptr = r_ptr + ADDR_W'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_ptr   = '0;
            end
        endcase
    end

    // State, pointer and the dropped-write pulse. The error flag is
    // registered so it appears in the cycle after the discarded write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_erro  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
            r_erro  <= (r_state == ST_CLEAR) && i_escrita;
        end
    end

    assign o_clr_en       = (r_state == ST_CLEAR);
    assign o_clr_idx      = r_ptr;
    assign o_ocupado      = (r_state == ST_CLEAR);
    assign o_erro_escrita = r_erro;

endmodule

// File: rtl/banco_registradores_param.sv
// ============================================================================
// banco_registradores_param
// ----------------------------------------------------------------------------
// Parametrised two-read / one-write register file with same-cycle write
// bypass, a valid bit per register and a sequenced soft-clear engine.
//
// Parameters: DATA_W (data width), ADDR_W (DEPTH = 2**ADDR_W), BYPASS (1 =
// forward a same-cycle write to matching read ports).
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   reg1, reg2   in   read addresses
//   regE         in   write address
//   EscData      in   write data
//   escrita      in   write enable
//   limpa        in   soft-clear request
//   out1, out2   out  read data
//   valido1/2    out  valid bit of the addressed register
//   ocupado      out  clear engine active
//   erro_escrita out  one-cycle pulse: write dropped during a clear
//
// Build option: define ZERO_REG_EN to hardwire register 0 (reads 0, valid 1,
// writes to it ignored without raising erro_escrita).
// ============================================================================
module banco_registradores_param
    import banco_registradores_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] reg1,
    input  logic [ADDR_W-1:0] reg2,
    input  logic [ADDR_W-1:0] regE,
    input  logic [DATA_W-1:0] EscData,
    input  logic              escrita,
    input  logic              limpa,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic              valido1,
    output logic              valido2,
    output logic              ocupado,
    output logic              erro_escrita
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;

    logic              w_wr_blocked;
    logic              w_escrita_eff;
    logic              w_wr_en;
    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_ocupado;
    logic [DATA_W-1:0] w_out1;
    logic [DATA_W-1:0] w_out2;
    logic              w_valido1;
    logic              w_valido2;

`ifdef ZERO_REG_EN
    // Writes to the hardwired register vanish entirely, so they are removed
    // before the clear engine can see them and report a dropped write.
    assign w_wr_blocked = (regE == '0);
`else
    assign w_wr_blocked = 1'b0;
`endif

    assign w_escrita_eff = escrita & ~w_wr_blocked;
    assign w_wr_en       = w_escrita_eff & ~w_ocupado;

    banco_limpeza_fsm #(
        .ADDR_W (ADDR_W)
    ) u_limpeza (
        .clock          (clock),
        .reset          (reset),
        .i_limpa        (limpa),
        .i_escrita      (w_escrita_eff),
        .o_clr_en       (w_clr_en),
        .o_clr_idx      (w_clr_idx),
        .o_ocupado      (w_ocupado),
        .o_erro_escrita (erro_escrita)
    );

    // Storage array. The clear sweep owns the array while active; writes are
    // only accepted in IDLE, so the two never compete for the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
        end else if (w_clr_en) begin
            r_mem[w_clr_idx]   <= '0;
            r_valid[w_clr_idx] <= 1'b0;
        end else if (w_wr_en) begin
            r_mem[regE]   <= EscData;
            r_valid[regE] <= 1'b1;
        end
    end

    // Read port 1: stored value, overridden by a same-cycle write to the
    // same address when bypass is built in, then by the hardwired zero.
    always_comb begin
        w_out1    = r_mem[reg1];
        w_valido1 = r_valid[reg1];
        if ((BYPASS != 0) && w_wr_en && (regE == reg1)) begin
            w_out1    = EscData;
            w_valido1 = 1'b1;
        end
`ifdef ZERO_REG_EN
        if (reg1 == '0) begin
            w_out1    = '0;
            w_valido1 = 1'b1;
        end
`endif
    end

    // Read port 2: identical selection to port 1.
    always_comb begin
        w_out2    = r_mem[reg2];
        w_valido2 = r_valid[reg2];
        if ((BYPASS != 0) && w_wr_en && (regE == reg2)) begin
            w_out2    = EscData;
            w_valido2 = 1'b1;
        end
`ifdef ZERO_REG_EN
        if (reg2 == '0) begin
            w_out2    = '0;
            w_valido2 = 1'b1;
        end
`endif
    end

    assign out1    = w_out1;
    assign out2    = w_out2;
    assign valido1 = w_valido1;
    assign valido2 = w_valido2;
    assign ocupado = w_ocupado;

endmodule

// File: doc/banco_registradores_param.md
Name: banco_registradores_param

Overview:
Parametrised successor to the 8x8 two-read/one-write register file. It is generalised in data width and depth, and adds:
- same-cycle write-to-read bypass
- a per-register valid bit
- a sequenced soft-clear engine with a busy flag and a dropped-write error pulse

It sits in the processor datapath between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 8, register data width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = a write in the same cycle is forwarded to matching read ports; 0 = reads show stored value only

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
reg1  input  ADDR_W  read address, port 1
reg2  input  ADDR_W  read address, port 2
regE  input  ADDR_W  write address
EscData  input  DATA_W  write data
escrita  input  1  write enable
limpa  input  1  soft-clear request, sampled per cycle
out1  output  DATA_W  read data, port 1
out2  output  DATA_W  read data, port 2
valido1  output  1  valid bit of the register addressed by port 1
valido2  output  1  valid bit of the register addressed by port 2
ocupado  output  1  clear engine active
erro_escrita  output  1  one-cycle pulse: write dropped during clear

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0, all valid bits = 0
  - FSM = IDLE, clear pointer = 0
  - ocupado = 0, erro_escrita = 0
  - out/valido then reflect the cleared storage (0/0)
- Reads are combinational from storage.
- Bypass, when BYPASS=1, escrita=1, IDLE and regE==regN:
  - outN = EscData
  - validoN = 1
- Write (IDLE, escrita=1) at the rising edge:
  - mem[regE] <= EscData
  - valid[regE] <= 1
  - stored value is visible from the following cycle
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when limpa=1 at an edge; pointer <= 0.
  - In CLEAR, each edge: mem[ptr] <= 0, valid[ptr] <= 0, ptr <= ptr+1.
  - After clearing entry DEPTH-1: -> IDLE, ptr <= 0.
  - The clear occupies exactly DEPTH cycles.
- ocupado = (state==CLEAR), a registered state decode.
- limpa while in CLEAR: ignored (no restart, no extension).
- escrita=1 while in CLEAR:
  - write discarded, no bypass
  - erro_escrita = 1 for the following cycle (registered pulse, one per dropped write)
- limpa=1 and escrita=1 together in IDLE:
  - the write is performed at that edge
  - the subsequent clear later zeroes it
- Reads during CLEAR return the current stored contents; entries not yet cleared keep their old data and valid bit.
- Pointer wrap: ptr is ADDR_W bits and wraps to 0 at the end of the clear. There are no out-of-range addresses since DEPTH = 2**ADDR_W.
- Reset asserted mid-clear: immediate return to IDLE with everything zeroed.
- reg1==reg2: both ports return identical data.

Optional Feature:
Macro ZERO_REG_EN.
- Defined:
  - register 0 is hardwired: out=0 and valido=1 whenever address 0 is read, including under bypass
  - writes to regE=0 are ignored, with no erro_escrita
  - the clear engine still steps over index 0, so the clear duration is unchanged
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE, ST_CLEAR) and the default DATA_W/ADDR_W constants for the processor.
- One natural sub-module, banco_limpeza_fsm. It holds the state, pointer, ocupado and erro_escrita. It outputs the clear-enable and clear-index to the storage array.
- Storage, read muxes and bypass stay in the top module.

Test Plan (DATA_W=8, ADDR_W=3, BYPASS=1):
1. Reset then write: reset=0 for 2 cycles, release; write 0x43 to reg 5.
   -> Next cycle reg1=5 gives out1=0x43, valido1=1.
   -> reg2=6 gives out2=0x00, valido2=0.
2. Bypass: escrita=1, regE=2, EscData=0xA5, reg1=2, reg2=3 in the same cycle.
   -> Same cycle out1=0xA5, valido1=1; out2 = stored reg 3.
   -> With BYPASS=0: out1 = old value.
3. Soft clear: fill regs 0..7 with 0x10..0x17; pulse limpa.
   -> ocupado=1 for exactly 8 cycles.
   -> Mid-clear, reg 7 still reads 0x17.
   -> Afterwards all regs read 0, valido=0.
4. Write during clear: escrita=1, regE=4, 0xFF in the 3rd clear cycle.
   -> erro_escrita=1 for exactly one cycle.
   -> After the clear, reg 4 = 0x00.
   -> A second limpa during the clear leaves the duration at 8 cycles.
5. Reset mid-clear: reset=0 in the 4th clear cycle.
   -> ocupado=0 immediately; all regs 0.
   -> A new limpa starts a fresh 8-cycle clear.
6. ZERO_REG_EN defined: write 0x55 to reg 0.
   -> out1 = 0x00, valido1 = 1, no erro_escrita, including on the bypass path.
